// File: rtl/full_adder_pkg.sv
// Shared types and constants for the single-bit full adder.
// The registered result is held as a {cout, sum} pair.
package full_adder_pkg;

    typedef struct packed {
        logic cout;
        logic sum;
    } adder_result_t;

    localparam adder_result_t ADDER_RESET_VAL = '0;

endpackage : full_adder_pkg

// File: rtl/half_adder.sv
// Combinational half adder: sum is the XOR of the inputs, carry is the AND.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic sum_o,
    output logic carry_o
);

    assign sum_o   = a_i ^ b_i;
    assign carry_o = a_i & b_i;

endmodule : half_adder

// File: rtl/full_adder_half_adder.sv
// Single-bit full adder built from two half adders and a carry OR.
// REG_OUT selects a registered output (one-cycle latency) or a purely combinational one.
module full_adder_half_adder
    import full_adder_pkg::*;
#(
    parameter int REG_OUT = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic p;
    logic g1;
    logic s;
    logic g2;
    logic c;

    half_adder u_ha_stage1 (
        .a_i     (a_i),
        .b_i     (b_i),
        .sum_o   (p),
        .carry_o (g1)
    );

    half_adder u_ha_stage2 (
        .a_i     (p),
        .b_i     (cin_i),
        .sum_o   (s),
        .carry_o (g2)
    );

    // The two generate terms can never both be 1, so OR is an exact carry.
    assign c = g1 | g2;

    generate
        if (REG_OUT != 0) begin : g_reg
            adder_result_t result_q;

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    result_q <= ADDER_RESET_VAL;
                end else begin
                    result_q <= '{cout: c, sum: s};
                end
            end

            assign sum_o  = result_q.sum;
            assign cout_o = result_q.cout;
        end else begin : g_comb
            // Clock and reset have no function in the combinational variant.
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i | reset_i;

            assign sum_o  = s;
            assign cout_o = c;
        end
    endgenerate

endmodule : full_adder_half_adder

// File: tb/tb_full_adder_half_adder.sv
// Directed self-checking bench for full_adder_half_adder, covering the registered
// and combinational variants.
`timescale 1ns/1ps
module tb_full_adder_half_adder;

    logic clk;
    logic rst;
    logic a, b, cin;
    logic sum_r, cout_r;
    logic ca, cb, ccin;
    logic sum_c, cout_c;

    int checks;
    int errors;

    // Expected {cout,sum} indexed by {cin,b,a}.
    logic [1:0] exp_tbl [8];

    full_adder_half_adder #(.REG_OUT(1)) dut_reg (
        .clk_i   (clk),
        .reset_i (rst),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .sum_o   (sum_r),
        .cout_o  (cout_r)
    );

    full_adder_half_adder #(.REG_OUT(0)) dut_comb (
        .clk_i   (clk),
        .reset_i (rst),
        .a_i     (ca),
        .b_i     (cb),
        .cin_i   (ccin),
        .sum_o   (sum_c),
        .cout_o  (cout_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst = 1'b1;
        a = 1'b1; b = 1'b1; cin = 1'b1;
        #1;
        checks++;
        if ({cout_r, sum_r} !== 2'b00) begin
            errors++;
            $display("FAIL reset_async_initial: got %b expected 00", {cout_r, sum_r});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({cout_r, sum_r} !== 2'b00) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected 00", i, {cout_r, sum_r});
            end
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({cout_r, sum_r} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release: got %b expected 11", {cout_r, sum_r});
        end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({cout_r, sum_r} !== 2'b00) begin
            errors++;
            $display("FAIL reset_between_edges: got %b expected 00", {cout_r, sum_r});
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_sweep();
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            a = v[0]; b = v[1]; cin = v[2];
            @(posedge clk); #1;
            checks++;
            if ({cout_r, sum_r} !== exp_tbl[v]) begin
                errors++;
                $display("FAIL sweep[%0d]: got %b expected %b", v, {cout_r, sum_r}, exp_tbl[v]);
            end
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        a = 1'b0; b = 1'b0; cin = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sum_r !== 1'b0) begin
            errors++;
            $display("FAIL latency_base: got %b expected 0", sum_r);
        end
        @(negedge clk); #2;
        a = 1'b1;
        #1;
        checks++;
        if (sum_r !== 1'b0) begin
            errors++;
            $display("FAIL latency_before_edge: got %b expected 0", sum_r);
        end
        @(posedge clk); #1;
        checks++;
        if (sum_r !== 1'b1) begin
            errors++;
            $display("FAIL latency_after_edge: got %b expected 1", sum_r);
        end
        @(negedge clk); #1;
        checks++;
        if (sum_r !== 1'b1) begin
            errors++;
            $display("FAIL latency_hold: got %b expected 1", sum_r);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        a = 1'b1; b = 1'b1; cin = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cout_r, sum_r} !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_pre: got %b expected 11", {cout_r, sum_r});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cout_r, sum_r} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_drop: got %b expected 00", {cout_r, sum_r});
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({cout_r, sum_r} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_released_no_edge: got %b expected 00", {cout_r, sum_r});
        end
        @(posedge clk); #1;
        checks++;
        if ({cout_r, sum_r} !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_recover: got %b expected 11", {cout_r, sum_r});
        end
    endtask

    task automatic test_comb();
        for (int v = 0; v < 8; v++) begin
            ca = v[0]; cb = v[1]; ccin = v[2];
            #1;
            checks++;
            if ({cout_c, sum_c} !== exp_tbl[v]) begin
                errors++;
                $display("FAIL comb[%0d]: got %b expected %b", v, {cout_c, sum_c}, exp_tbl[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] vec [3];
        logic [1:0] exp [3];
        vec[0] = 3'b111; exp[0] = 2'b11;
        vec[1] = 3'b000; exp[1] = 2'b00;
        vec[2] = 3'b110; exp[2] = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {cin, b, a} = vec[i];
            @(posedge clk); #1;
            checks++;
            if ({cout_r, sum_r} !== exp[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %b expected %b", i, {cout_r, sum_r}, exp[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_tbl[0] = 2'b00; exp_tbl[1] = 2'b01; exp_tbl[2] = 2'b01; exp_tbl[3] = 2'b10;
        exp_tbl[4] = 2'b01; exp_tbl[5] = 2'b10; exp_tbl[6] = 2'b10; exp_tbl[7] = 2'b11;
        rst = 1'b1;
        a = 1'b0; b = 1'b0; cin = 1'b0;
        ca = 1'b0; cb = 1'b0; ccin = 1'b0;

        test_reset();
        test_sweep();
        test_latency();
        test_mid_reset();
        test_comb();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_full_adder_half_adder
